// File: rtl/write_32bit_data_checker.sv
// Sink-side pattern checker for the host->FPGA throughput test: drains the pipe FIFO, regenerates
// the expected pattern locally and accumulates word/error statistics plus the first mismatch.
module write_32bit_data_checker #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       CNT_W     = 64,
  parameter int unsigned       ERR_W     = 32,
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(32'h0000_0001)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [1:0]        pattern,
  input  logic              enable_check,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [CNT_W-1:0]  word_count,
  output logic [ERR_W-1:0]  error_count,
  output logic              error_flag,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_rcv,
  output logic              busy
);

  localparam logic [DATA_W-1:0] LfsrTaps = DATA_W'(32'h0040_0007);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q;
  logic              rd_valid_q;
  logic              seeded_q;
  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] exp_cur;
  logic              mismatch;

  function automatic logic [DATA_W-1:0] seed_of(input logic [1:0] p);
    logic [DATA_W-1:0] s;
    unique case (p)
      2'd0:    s = '0;
      2'd1:    s = DATA_W'(1);
      2'd2:    s = LFSR_SEED;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [1:0] p, input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] n;
    unique case (p)
      2'd0:    n = v + DATA_W'(1);
      2'd1:    n = {v[DATA_W-2:0], v[DATA_W-1]};
      2'd2:    n = {v[DATA_W-2:0], 1'b0} ^ (v[DATA_W-1] ? LfsrTaps : '0);
      default: n = ~v;
    endcase
    return n;
  endfunction

  // Until the first compare after reset/clear the expected word is the seed of the live pattern,
  // which keeps the async reset value constant while still tracking the pattern input.
  always_comb begin
    exp_cur    = seeded_q ? exp_q : seed_of(pattern);
    mismatch   = rd_valid_q && (fifo_dout != exp_cur);
    fifo_rd_en = (state_q == StRun) && enable_check && !fifo_empty && !clear;
  end

  assign busy = (state_q == StRun);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      rd_valid_q    <= 1'b0;
      seeded_q      <= 1'b0;
      exp_q         <= '0;
      word_count    <= '0;
      error_count   <= '0;
      error_flag    <= 1'b0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_rcv <= '0;
    end else begin
      state_q <= enable_check ? StRun : StIdle;
      if (clear) begin
        // Drops the word in flight; the FSM state is left alone.
        rd_valid_q    <= 1'b0;
        seeded_q      <= 1'b0;
        exp_q         <= '0;
        word_count    <= '0;
        error_count   <= '0;
        error_flag    <= 1'b0;
        first_err_idx <= '0;
        first_err_exp <= '0;
        first_err_rcv <= '0;
      end else begin
        rd_valid_q <= fifo_rd_en;
        if (rd_valid_q) begin
          exp_q      <= advance(pattern, exp_cur);
          seeded_q   <= 1'b1;
          word_count <= word_count + CNT_W'(1);
          if (mismatch) begin
            if (error_count != '1) error_count <= error_count + ERR_W'(1);
            error_flag <= 1'b1;
            if (!error_flag) begin
              first_err_idx <= word_count;
              first_err_exp <= exp_cur;
              first_err_rcv <= fifo_dout;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_write_32bit_data_checker.sv
// Randomized bench for write_32bit_data_checker: a FIFO model feeds two builds (ERR_W=32 and 4)
// and a pattern-indexed reference model predicts every output each cycle.
module tb_write_32bit_data_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        enable_check = 1'b0;
  logic        force_empty = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [31:0] fifo_dout = '0;
  logic        fifo_empty;

  logic        rd_en, rd_en2, flag, flag2, busy, busy2;
  logic [63:0] wc, wc2, fidx, fidx2;
  logic [31:0] ec, fexp, fexp2, frcv, frcv2;
  logic [3:0]  ec2;

  logic [31:0] mem [0:8191];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  int          n_rd = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // Reference model state
  logic        m_run, m_valid, m_flag, m_rd;
  logic [63:0] m_wc, m_fidx;
  logic [31:0] m_ec, m_fexp, m_frcv, m_exp;
  logic [3:0]  m_ec4;

  write_32bit_data_checker dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .pattern(pattern),
    .enable_check(enable_check), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(rd_en), .word_count(wc), .error_count(ec), .error_flag(flag),
    .first_err_idx(fidx), .first_err_exp(fexp), .first_err_rcv(frcv), .busy(busy)
  );

  write_32bit_data_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .pattern(pattern),
    .enable_check(enable_check), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(rd_en2), .word_count(wc2), .error_count(ec2), .error_flag(flag2),
    .first_err_idx(fidx2), .first_err_exp(fexp2), .first_err_rcv(frcv2), .busy(busy2)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr) || force_empty;

  // Standard-mode FIFO: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) n_rd <= n_rd + 1;
    if (rd_en && rd_ptr != wr_ptr) begin
      fifo_dout <= mem[rd_ptr % 8192];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // k-th word of each pattern, computed directly from its definition.
  function automatic logic [31:0] pat_word(input logic [1:0] p, input logic [63:0] k);
    logic [31:0] x;
    case (p)
      2'd0: return k[31:0];
      2'd1: return 32'h1 << k[4:0];
      2'd2: begin
        x = 32'h1;
        for (int i = 0; i < int'(k); i++) x = (x << 1) ^ (x[31] ? 32'h0040_0007 : 32'h0);
        return x;
      end
      default: return k[0] ? 32'hFFFF_FFFF : 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_valid = 0; m_wc = 0; m_ec = 0; m_ec4 = 0;
      m_flag = 0; m_fidx = 0; m_fexp = 0; m_frcv = 0;
    end else begin
      m_rd = m_run && enable_check && !fifo_empty && !clear;
      if (clear) begin
        m_valid = 0; m_wc = 0; m_ec = 0; m_ec4 = 0;
        m_flag = 0; m_fidx = 0; m_fexp = 0; m_frcv = 0;
      end else begin
        if (m_valid) begin
          m_exp = pat_word(pattern, m_wc);
          if (fifo_dout != m_exp) begin
            if (m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 1;
            if (m_ec4 != 4'hF) m_ec4 = m_ec4 + 1;
            if (!m_flag) begin
              m_fidx = m_wc; m_fexp = m_exp; m_frcv = fifo_dout;
            end
            m_flag = 1;
          end
          m_wc = m_wc + 1;
        end
        m_valid = m_rd;
      end
      m_run = enable_check;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always begin
    @(negedge clk);
    #1;
    chk("rd_en", {63'd0, rd_en}, {63'd0, m_run && enable_check && !fifo_empty && !clear});
    chk("rd_en_e4", {63'd0, rd_en2}, {63'd0, rd_en});
    chk("busy", {63'd0, busy}, {63'd0, m_run});
    chk("word_count", wc, m_wc);
    chk("error_count", {32'd0, ec}, {32'd0, m_ec});
    chk("error_count_e4", {60'd0, ec2}, {60'd0, m_ec4});
    chk("error_flag", {63'd0, flag}, {63'd0, m_flag});
    chk("first_err_idx", fidx, m_fidx);
    chk("first_err_exp", {32'd0, fexp}, {32'd0, m_fexp});
    chk("first_err_rcv", {32'd0, frcv}, {32'd0, m_frcv});
  end

  task automatic load(input logic [1:0] p, input int n, input int bad_a, input int bad_b,
                      input logic [31:0] xr);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = pat_word(p, i) ^ xr;
      if (i == bad_a || i == bad_b) w = w ^ 32'h1;
      mem[wr_ptr % 8192] = w;
      wr_ptr++;
    end
  endtask

  task automatic restart(input logic [1:0] p);
    @(negedge clk); enable_check = 0;
    repeat (3) @(negedge clk);
    pattern = p;
    clear = 1;
    @(negedge clk); clear = 0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (rd_ptr != wr_ptr && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_done", {63'd0, rd_ptr != wr_ptr}, 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int rd_base;
    // Pin the model itself
    chk("pin_ctr5", {32'd0, pat_word(2'd0, 5)}, 64'd5);
    chk("pin_walk32", {32'd0, pat_word(2'd1, 32)}, 64'h1);
    chk("pin_lfsr5", {32'd0, pat_word(2'd2, 5)}, 64'h20);
    chk("pin_lfsr32", {32'd0, pat_word(2'd2, 32)}, 64'h0040_0007);
    chk("pin_alt1", {32'd0, pat_word(2'd3, 1)}, 64'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    chk("reset_wc", wc, 64'd0);
    chk("reset_rd_en", {63'd0, rd_en}, 64'd0);
    reset_n = 1;

    // 1: counter, 1024 words
    restart(2'd0);
    load(2'd0, 1024, -1, -1, 32'h0);
    enable_check = 1;
    drain();
    chk("t1_wc", wc, 64'd1024);
    chk("t1_ec", {32'd0, ec}, 64'd0);
    chk("t1_flag", {63'd0, flag}, 64'd0);

    // 2: LFSR with words 5 and 9 corrupted
    restart(2'd2);
    load(2'd2, 12, 5, 9, 32'h0);
    enable_check = 1;
    drain();
    chk("t2_ec", {32'd0, ec}, 64'd2);
    chk("t2_idx", fidx, 64'd5);
    chk("t2_exp", {32'd0, fexp}, 64'h20);
    chk("t2_rcv", {32'd0, frcv}, 64'h21);

    // 3: walking-one across the bit31 wrap
    restart(2'd1);
    load(2'd1, 40, -1, -1, 32'h0);
    enable_check = 1;
    drain();
    chk("t3_wc", wc, 64'd40);
    chk("t3_ec", {32'd0, ec}, 64'd0);

    // 4: random empty gaps and enable drops mid-burst
    restart(2'd0);
    rd_base = n_rd;
    load(2'd0, 30, -1, -1, 32'h0);
    enable_check = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      force_empty  = (i % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      enable_check = !(i >= 15 && i < 18) && ($urandom_range(0, 7) != 0);
    end
    @(negedge clk); force_empty = 0; enable_check = 1;
    drain();
    chk("t4_wc", wc, 64'd30);
    chk("t4_wc_vs_rd", wc, 64'(n_rd - rd_base));
    chk("t4_ec", {32'd0, ec}, 64'd0);

    // 5: clear while words are being compared, then a mid-run reset pulse
    restart(2'd0);
    load(2'd0, 20, -1, -1, 32'h0);
    enable_check = 1;
    repeat (6) @(negedge clk);
    clear = 1;
    @(negedge clk); clear = 0;
    #1 chk("t5_clear_wc", wc, 64'd0);
    repeat (3) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("t5_rst_wc", wc, 64'd0);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_flag", {63'd0, flag}, 64'd0);
    chk("t5_rst_ec", {32'd0, ec}, 64'd0);
    @(negedge clk); reset_n = 1;
    drain();

    // 6: 20 bad words, narrow error counter saturates
    restart(2'd0);
    load(2'd0, 20, -1, -1, 32'hDEAD_BEEF);
    enable_check = 1;
    drain();
    chk("t6_ec4", {60'd0, ec2}, 64'd15);
    chk("t6_ec32", {32'd0, ec}, 64'd20);
    chk("t6_idx", fidx, 64'd0);

    enable_check = 0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
